// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reducer.
// Each lane derives M = floor(2^K / Q) and its width from these functions.
package barrett_pkg;

  localparam longint unsigned Q_KYBER     = 64'd3329;
  localparam longint unsigned Q_DILITHIUM = 64'd8380417;

  function automatic longint unsigned barrett_m(input longint unsigned q, input int k);
    return (64'd1 << k) / q;
  endfunction

  function automatic int bit_width(input longint unsigned v);
    return $clog2(v + 64'd1);
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe_lane.sv
// Single-lane three-stage Barrett datapath: c*M, c - qe*Q, final conditional subtract.
// Valid bits live in the parent; this lane only advances on the per-stage enables.
module barrett_lane
  import barrett_pkg::*;
#(
  parameter int              IN_W  = 32,
  parameter longint unsigned Q     = Q_KYBER,
  parameter int              OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en1,
  input  logic             i_en2,
  input  logic             i_en3,
  input  logic [IN_W-1:0]  i_c,
  output logic [OUT_W-1:0] o_res
);

  localparam longint unsigned M   = barrett_m(Q, IN_W);
  localparam int              M_W = bit_width(M);
  localparam int              P_W = IN_W + M_W;

  logic [IN_W-1:0]  r_c1;
  logic [P_W-1:0]   r_p1;
  logic [IN_W:0]    r_r2;
  logic [OUT_W-1:0] r_res3;

  logic [P_W-1:0]   w_p;
  logic [M_W-1:0]   w_qe;
  logic [IN_W:0]    w_qeq;
  logic [IN_W:0]    w_r;
  logic [IN_W:0]    w_sub;

  assign w_p   = P_W'(i_c) * P_W'(M);
  assign w_qe  = r_p1[P_W-1:IN_W];
  assign w_qeq = (IN_W+1)'(w_qe) * (IN_W+1)'(Q);
  // qe underestimates c/Q by at most one, so r is already in [0, 2Q)
  assign w_r   = {1'b0, r_c1} - w_qeq;
  assign w_sub = (r_r2 >= (IN_W+1)'(Q)) ? (r_r2 - (IN_W+1)'(Q)) : r_r2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1   <= '0;
      r_p1   <= '0;
      r_r2   <= '0;
      r_res3 <= '0;
    end else begin
      if (i_en1) begin
        r_c1 <= i_c;
        r_p1 <= w_p;
      end
      if (i_en2) r_r2 <= w_r;
      if (i_en3) r_res3 <= OUT_W'(w_sub);
    end
  end

  assign o_res = r_res3;

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Multi-lane pipelined Barrett reducer with valid/ready back-pressure, tag sideband and flush.
// Stage enables ripple back from out_ready, so an empty stage always pulls from the one before.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int              IN_W  = 32,
  parameter longint unsigned Q     = Q_KYBER,
  parameter int              OUT_W = 16,
  parameter int              LANES = 1,
  parameter int              TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag
);

  if ((64'd1 << OUT_W) <= Q) begin : g_bad_out_w
    $error("barrett_reduce_pipe: OUT_W too narrow for Q");
  end
  if (IN_W < 2 || IN_W > 48) begin : g_bad_in_w
    $error("barrett_reduce_pipe: IN_W out of range");
  end

  logic             r_v1, r_v2, r_v3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic             w_en1, w_en2, w_en3;

  assign w_en3 = ~r_v3 | out_ready;
  assign w_en2 = ~r_v2 | w_en3;
  assign w_en1 = ~r_v1 | w_en2;

  // flush wins over every enable so a beat offered alongside it is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else begin
      if (w_en1) begin
        r_v1   <= in_valid;
        r_tag1 <= in_tag;
      end
      if (w_en2) begin
        r_v2   <= r_v1;
        r_tag2 <= r_tag1;
      end
      if (w_en3) begin
        r_v3   <= r_v2;
        r_tag3 <= r_tag2;
      end
      if (flush) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    barrett_lane #(
      .IN_W (IN_W),
      .Q    (Q),
      .OUT_W(OUT_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en1(w_en1),
      .i_en2(w_en2),
      .i_en3(w_en3),
      .i_c  (in_data[i*IN_W +: IN_W]),
      .o_res(out_data[i*OUT_W +: OUT_W])
    );
  end

  assign in_ready  = w_en1;
  assign out_valid = r_v3;
  assign out_tag   = r_tag3;

endmodule
